adder_carry_serial_driver: RTL and testbench



---
 rtl/adder_carry_serial_driver.sv | 134 +++++++++++++
 tb/tb_adder_carry_serial_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_carry_serial_driver.sv
// Bit-serial initiator for one external adder_carry cell: feeds p/g/cin LSB first,
// chains cout back as cin, and returns the sum. Build with ADDER_CARRY_SERIAL_SUB_EN for A-B support.
module adder_carry_serial_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDER_CARRY_SERIAL_SUB_EN
    input  logic             sub_mode,
`endif
    output logic             adder_carry_p,
    output logic             adder_carry_g,
    output logic             adder_carry_cin,
    input  logic             adder_carry_sumout,
    input  logic             adder_carry_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             carry;
    } opnd_t;

    state_e           state_q, state_d;
    opnd_t            op_q, op_d;
    opnd_t            op_acc;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic [WIDTH-1:0] sum_shift;

    // Operand pair as it will be loaded on acceptance; subtraction is A + ~B + 1.
    always_comb begin
        op_acc.a     = in_a;
        op_acc.b     = in_b;
        op_acc.carry = in_cin;
`ifdef ADDER_CARRY_SERIAL_SUB_EN
        if (sub_mode) begin
            op_acc.b     = ~in_b;
            op_acc.carry = 1'b1;
        end
`endif
    end

    assign sum_shift = {adder_carry_sumout, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
        end
    end

    // p/g/cin depend only on flops, so the cell sees edge-aligned inputs.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cnt_d           = cnt_q;
        sum_d           = sum_q;
        out_sum_d       = out_sum_q;
        out_cout_d      = out_cout_q;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        adder_carry_p   = 1'b0;
        adder_carry_g   = 1'b0;
        adder_carry_cin = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op_acc;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                adder_carry_p   = op_q.a[0] ^ op_q.b[0];
                adder_carry_g   = op_q.a[0];
                adder_carry_cin = op_q.carry;
                sum_d           = sum_shift;
                op_d.a          = op_q.a >> 1;
                op_d.b          = op_q.b >> 1;
                op_d.carry      = adder_carry_cout;
                if (cnt_q == LAST) begin
                    out_sum_d  = sum_shift;
                    out_cout_d = adder_carry_cout;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_sum  = out_sum_q;
    assign out_cout = out_cout_q;

endmodule

// File: tb/tb_adder_carry_serial_driver.sv
// Directed bench for adder_carry_serial_driver (WIDTH=8) with a behavioural adder_carry cell.
module tb_adder_carry_serial_driver;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef ADDER_CARRY_SERIAL_SUB_EN
    logic         sub_mode;
`endif
    logic         ac_p, ac_g, ac_cin;
    logic         ac_sumout, ac_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural adder_carry cell
    assign ac_sumout = ac_p ^ ac_cin;
    assign ac_cout   = ac_p ? ac_cin : ac_g;

    adder_carry_serial_driver #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_a              (in_a),
        .in_b              (in_b),
        .in_cin            (in_cin),
`ifdef ADDER_CARRY_SERIAL_SUB_EN
        .sub_mode          (sub_mode),
`endif
        .adder_carry_p     (ac_p),
        .adder_carry_g     (ac_g),
        .adder_carry_cin   (ac_cin),
        .adder_carry_sumout(ac_sumout),
        .adder_carry_cout  (ac_cout),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_sum           (out_sum),
        .out_cout          (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 in IDLE; returns at posedge+1 of the first out_valid cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic sm, output logic [W-1:0] s, output logic co,
                         output int lat, output logic [W-1:0] pseq);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
`ifdef ADDER_CARRY_SERIAL_SUB_EN
        sub_mode = sm;
`else
        if (sm) $display("note: sub_mode request ignored in add-only build");
`endif
        step();
        in_valid = 1'b0;
        lat = 0;
        pseq = '0;
        while (!out_valid && lat < 20) begin
            if (lat < W) pseq[lat] = ac_p;
            step();
            lat++;
        end
        chk("op_out_valid", 32'(out_valid), 32'd1);
        s  = out_sum;
        co = out_cout;
    endtask

    logic [W-1:0] s, pseq;
    logic         co;
    int           lat;

    initial begin
        logic [W-1:0] ra[4], rb[4];
        logic         rc[4];
        logic [W:0]   exp_r;
        int           idx, nres, cyc, last_cyc, vcnt;
        logic         prev_rdy;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef ADDER_CARRY_SERIAL_SUB_EN
        sub_mode = 1'b0;
`endif
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        chk("rst_pgc", {29'd0, ac_p, ac_g, ac_cin}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // 0x5A + 0x3C
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, s, co, lat, pseq);
        chk("t1_sum", 32'(s), 32'h96);
        chk("t1_cout", 32'(co), 32'd0);
        chk("t1_latency", 32'(lat + 1), 32'd9);
        chk("t1_pseq", 32'(pseq), 32'h66);
        step();

        do_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, lat, pseq);
        chk("t2_sum", 32'(s), 32'h00);
        chk("t2_cout", 32'(co), 32'd1);
        step();

        do_op(8'h00, 8'h00, 1'b1, 1'b0, s, co, lat, pseq);
        chk("t3_sum", 32'(s), 32'h01);
        chk("t3_cout", 32'(co), 32'd0);
        step();

        // Backpressure: result must hold, pulsed in_valid must be ignored
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, 1'b0, s, co, lat, pseq);
        chk("bp_sum0", 32'(s), 32'h46);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_a = 8'h77; in_b = 8'h11; in_valid = 1'b1; end
            if (i == 2) in_valid = 1'b0;
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'h46);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
        chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
        chk("bp_rel_sum_hold", 32'(out_sum), 32'h46);
        step();
        chk("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset during RUN of 0xAA + 0x55
        in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mr_run_p", 32'(ac_p), 32'd1);
        chk("mr_run_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_sum", 32'(out_sum), 32'd0);
        chk("mr_p", 32'(ac_p), 32'd0);
        step();
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) vcnt++;
        end
        chk("mr_no_result", 32'(vcnt), 32'd0);
        chk("mr_idle", 32'(in_ready), 32'd1);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, s, co, lat, pseq);
        chk("mr_next_sum", 32'(s), 32'h02);
        chk("mr_next_cout", 32'(co), 32'd0);
        step();

        // Back-to-back with in_valid held high
        for (int i = 0; i < 4; i++) begin
            ra[i] = W'($urandom);
            rb[i] = W'($urandom);
            rc[i] = 1'($urandom);
        end
        idx = 0; nres = 0; cyc = 0; last_cyc = 0;
        in_a = ra[0]; in_b = rb[0]; in_cin = rc[0]; in_valid = 1'b1;
        while (nres < 4 && cyc < 100) begin
            prev_rdy = in_ready;
            step();
            cyc++;
            if (prev_rdy && idx < 4) begin
                idx++;
                if (idx < 4) begin
                    in_a = ra[idx]; in_b = rb[idx]; in_cin = rc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                exp_r = {1'b0, ra[nres]} + {1'b0, rb[nres]} + {{W{1'b0}}, rc[nres]};
                chk("b2b_sum", 32'(out_sum), 32'(exp_r[W-1:0]));
                chk("b2b_cout", 32'(out_cout), 32'(exp_r[W]));
                if (nres > 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'd10);
                last_cyc = cyc;
                nres++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(nres), 32'd4);
        step();

`ifdef ADDER_CARRY_SERIAL_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, s, co, lat, pseq);
        chk("sub1_sum", 32'(s), 32'h0F);
        chk("sub1_cout", 32'(co), 32'd1);
        step();
        do_op(8'h01, 8'h02, 1'b0, 1'b1, s, co, lat, pseq);
        chk("sub2_sum", 32'(s), 32'hFF);
        chk("sub2_cout", 32'(co), 32'd0);
        step();
        do_op(8'h10, 8'h01, 1'b1, 1'b0, s, co, lat, pseq);
        chk("sub_off_sum", 32'(s), 32'h12);
        chk("sub_off_cout", 32'(co), 32'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
